// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory arbiter.
package mem_arb_pkg;

  // Who won the memory port in a given cycle.
  typedef enum logic [1:0] {
    GS_NONE = 2'd0,
    GS_DATA = 2'd1,
    GS_INST = 2'd2
  } gnt_state_e;

  // Return-tag source encodings.
  localparam logic SRC_IF = 1'b0;
  localparam logic SRC_D  = 1'b1;

  // One in-flight access: valid only for reads that will return data.
  typedef struct packed {
    logic valid;
    logic src;
  } tag_t;

endpackage

// File: rtl/arb_tag_pipe.sv
// Return-tag shift register: one entry per cycle of memory latency, head is the
// access whose read data is on mem_rdata this cycle. Flush kills fetch entries.
module arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  tag_t push_i,
  input  logic flush_i,
  output tag_t head_o
);

  tag_t [Depth-1:0] pipe_q, pipe_d;

  function automatic tag_t squash(input tag_t t, input logic flush);
    tag_t r;
    r = t;
    if (flush && (t.src == SRC_IF)) begin
      r.valid = 1'b0;
    end
    return r;
  endfunction

  // Shift toward the head, clearing fetch entries (including the new one) on flush.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = squash(push_i, flush_i);
    for (int unsigned i = 1; i < Depth; i++) begin
      pipe_d[i] = squash(pipe_q[i-1], flush_i);
    end
  end

  // Tag storage; reset drops every pending return.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign head_o = pipe_q[Depth-1];

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported unified memory between fetch (IF) and the
// load/store port, routing read data back after a fixed latency.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              stall_if,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall_mem,
  input  logic              flush,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] StarveMax = 3'(STARVE_MAX);

  logic [2:0]        starve_q, starve_d;
  gnt_state_e        state_q, state_d;
  logic              if_force;
  tag_t              push, head;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  // Data wins unless IF has waited STARVE_MAX cycles; reset blocks all grants.
  always_comb begin
    if_force  = if_req && (starve_q == StarveMax);
    d_gnt     = reset && d_req && !if_force;
    if_gnt    = reset && if_req && !d_gnt;
    stall_if  = reset && if_req && !if_gnt;
    stall_mem = reset && d_req && !d_gnt;
  end

  // Next starvation count and grant state.
  always_comb begin
    starve_d = 3'd0;
    if (if_req && !if_gnt) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 3'd1;
    end
    if (d_gnt) begin
      state_d = GS_DATA;
    end else if (if_gnt) begin
      state_d = GS_INST;
    end else begin
      state_d = GS_NONE;
    end
  end

  // Grant state machine and starvation counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= GS_NONE;
      starve_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Drive the memory with the winner's fields; everything low when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end
  end

  // Only reads carry a valid return tag.
  always_comb begin
    push.valid = (d_gnt && !d_we) || if_gnt;
    push.src   = d_gnt ? SRC_D : SRC_IF;
  end

  arb_tag_pipe #(
    .Depth (MEM_LAT)
  ) u_tag_pipe (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (push),
    .flush_i (flush),
    .head_o  (head)
  );

  // Route the returning word to its requester; the other port keeps its last word.
  always_comb begin
    if_rvalid = head.valid && (head.src == SRC_IF);
    d_rvalid  = head.valid && (head.src == SRC_D);
    if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
    d_rdata   = d_rvalid ? mem_rdata : d_rdata_q;
  end

  // Hold registers for the read-data outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (if_rvalid) begin
        if_rdata_q <= mem_rdata;
      end
      if (d_rvalid) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  // An IF win always restarts the starvation count.
  assert property (@(posedge clock) disable iff (!reset)
                   (state_q == GS_INST) |-> (starve_q == 3'd0));

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: instance A (MEM_LAT=1) for reset, contention, starvation,
// store/load and mid-access reset; instance B (MEM_LAT=3) for flush.
module tb_unified_mem_arbiter;

  logic clock = 1'b0;
  initial forever #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A signals
  logic        a_rst, a_if_req, a_d_req, a_d_we, a_flush;
  logic [31:0] a_if_addr, a_d_addr, a_d_wdata, a_mem_rdata;
  logic        a_if_gnt, a_if_rvalid, a_stall_if, a_d_gnt, a_d_rvalid, a_stall_mem;
  logic        a_mem_en, a_mem_we;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;

  // Instance B signals
  logic        b_rst, b_if_req, b_d_req, b_d_we, b_flush;
  logic [31:0] b_if_addr, b_d_addr, b_d_wdata, b_mem_rdata;
  logic        b_if_gnt, b_if_rvalid, b_stall_if, b_d_gnt, b_d_rvalid, b_stall_mem;
  logic        b_mem_en, b_mem_we;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;

  unified_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)
  ) dut_a (
    .clock(clock), .reset(a_rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid),
    .if_rdata(a_if_rdata), .stall_if(a_stall_if),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata), .stall_mem(a_stall_mem),
    .flush(a_flush), .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  unified_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)
  ) dut_b (
    .clock(clock), .reset(b_rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
    .if_rdata(b_if_rdata), .stall_if(b_stall_if),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata), .stall_mem(b_stall_mem),
    .flush(b_flush), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Unwritten memory words read as {16'hC0DE, addr[15:0]}.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Memory model A: one-cycle read latency, writes visible to later reads.
  logic [31:0]  a_store [0:255];
  logic [255:0] a_wr = '0;
  logic [31:0]  a_p0 = '0;
  always @(posedge clock) begin
    if (a_mem_en && a_mem_we) begin
      a_store[a_mem_addr[9:2]] <= a_mem_wdata;
      a_wr[a_mem_addr[9:2]]    <= 1'b1;
    end
    if (a_mem_en && !a_mem_we) begin
      a_p0 <= a_wr[a_mem_addr[9:2]] ? a_store[a_mem_addr[9:2]] : init_word(a_mem_addr);
    end else begin
      a_p0 <= 32'h0;
    end
  end
  assign a_mem_rdata = a_p0;

  // Memory model B: read-only, three-cycle latency.
  logic [31:0] b_p0 = '0, b_p1 = '0, b_p2 = '0;
  always @(posedge clock) begin
    b_p0 <= (b_mem_en && !b_mem_we) ? init_word(b_mem_addr) : 32'h0;
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign b_mem_rdata = b_p2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next;
    @(posedge clock);
    #1;
  endtask

  task automatic sample;
    @(negedge clock);
  endtask

  initial begin
    a_rst = 1'b0; a_if_req = 1'b1; a_if_addr = 32'h100;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h200; a_d_wdata = 32'h0; a_flush = 1'b0;
    b_rst = 1'b0; b_if_req = 1'b0; b_if_addr = 32'h0;
    b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = 32'h0; b_d_wdata = 32'h0; b_flush = 1'b0;

    // Reset held with both requests high
    sample;
    chk("rst_if_gnt", a_if_gnt, 0);
    chk("rst_d_gnt", a_d_gnt, 0);
    chk("rst_stall_if", a_stall_if, 0);
    chk("rst_stall_mem", a_stall_mem, 0);
    chk("rst_mem_en", a_mem_en, 0);
    chk("rst_mem_addr", a_mem_addr, 0);
    chk("rst_if_rvalid", a_if_rvalid, 0);
    chk("rst_d_rvalid", a_d_rvalid, 0);
    chk("rst_d_rdata", a_d_rdata, 0);
    chk("rst_if_rdata", a_if_rdata, 0);

    // Release: IF alone at 0x100 granted immediately
    next; a_rst = 1'b1; b_rst = 1'b1; a_d_req = 1'b0;
    sample;
    chk("first_if_gnt", a_if_gnt, 1);
    chk("first_mem_en", a_mem_en, 1);
    chk("first_mem_addr", a_mem_addr, 32'h100);
    chk("first_mem_we", a_mem_we, 0);
    next; a_if_req = 1'b0;
    sample;
    chk("first_if_rvalid", a_if_rvalid, 1);
    chk("first_if_rdata", a_if_rdata, 32'hC0DE0100);
    chk("idle_mem_en", a_mem_en, 0);

    // Contention: data load beats IF
    next; a_if_req = 1'b1; a_if_addr = 32'h104; a_d_req = 1'b1; a_d_addr = 32'h200;
    sample;
    chk("cont_d_gnt", a_d_gnt, 1);
    chk("cont_if_gnt", a_if_gnt, 0);
    chk("cont_stall_if", a_stall_if, 1);
    chk("cont_mem_addr", a_mem_addr, 32'h200);
    next; a_d_req = 1'b0;
    sample;
    chk("cont_d_rvalid", a_d_rvalid, 1);
    chk("cont_d_rdata", a_d_rdata, 32'hC0DE0200);
    chk("cont_if_gnt2", a_if_gnt, 1);
    next; a_if_req = 1'b0;
    sample;
    chk("cont_if_rvalid", a_if_rvalid, 1);
    chk("cont_if_rdata", a_if_rdata, 32'hC0DE0104);
    chk("cont_d_rvalid_low", a_d_rvalid, 0);
    chk("cont_d_rdata_hold", a_d_rdata, 32'hC0DE0200);

    // Starvation: four data grants, IF forced in the fifth cycle
    next; a_if_req = 1'b1; a_if_addr = 32'h108; a_d_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_d_addr = 32'h300 + 32'(4 * i);
      sample;
      chk("starve_d_gnt", a_d_gnt, 1);
      chk("starve_stall_if", a_stall_if, 1);
      if (i > 0) begin
        chk("starve_d_rvalid", a_d_rvalid, 1);
        chk("starve_d_rdata", a_d_rdata, 32'hC0DE0300 + 32'(4 * (i - 1)));
      end
      next;
    end
    a_d_addr = 32'h310;
    sample;
    chk("starve_if_gnt", a_if_gnt, 1);
    chk("starve_d_denied", a_d_gnt, 0);
    chk("starve_stall_mem", a_stall_mem, 1);
    chk("starve_mem_addr", a_mem_addr, 32'h108);
    chk("starve_last_d_rdata", a_d_rdata, 32'hC0DE030C);
    next; a_if_addr = 32'h10C;
    sample;
    chk("resume_d_gnt", a_d_gnt, 1);
    chk("resume_if_denied", a_if_gnt, 0);
    chk("resume_if_rvalid", a_if_rvalid, 1);
    chk("resume_if_rdata", a_if_rdata, 32'hC0DE0108);
    next; a_d_req = 1'b0;
    sample;
    chk("resume_if_gnt", a_if_gnt, 1);
    chk("resume_d_rdata", a_d_rdata, 32'hC0DE0310);
    next; a_if_req = 1'b0;
    sample;
    chk("resume_if_rdata2", a_if_rdata, 32'hC0DE010C);

    // Store then load to the same address
    next; a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 32'h40; a_d_wdata = 32'hDEADBEEF;
    sample;
    chk("st_d_gnt", a_d_gnt, 1);
    chk("st_mem_we", a_mem_we, 1);
    chk("st_mem_wdata", a_mem_wdata, 32'hDEADBEEF);
    chk("st_mem_addr", a_mem_addr, 32'h40);
    next; a_d_we = 1'b0;
    sample;
    chk("st_no_rvalid", a_d_rvalid, 0);
    chk("ld_mem_we", a_mem_we, 0);
    next; a_d_req = 1'b0;
    sample;
    chk("ld_d_rvalid", a_d_rvalid, 1);
    chk("ld_d_rdata", a_d_rdata, 32'hDEADBEEF);

    // Reset while a load is in flight
    next; a_d_req = 1'b1; a_d_addr = 32'h204;
    sample;
    chk("mid_d_gnt", a_d_gnt, 1);
    next; a_d_req = 1'b0; a_rst = 1'b0;
    sample;
    chk("mid_d_rvalid", a_d_rvalid, 0);
    chk("mid_d_rdata", a_d_rdata, 0);
    chk("mid_if_rdata", a_if_rdata, 0);
    next; a_rst = 1'b1;
    sample;
    chk("mid_rel_d_rvalid", a_d_rvalid, 0);
    chk("mid_rel_if_rvalid", a_if_rvalid, 0);
    next;
    sample;
    chk("mid_rel_d_rvalid2", a_d_rvalid, 0);

    // Instance B: plain fetch with three-cycle latency
    next; b_if_req = 1'b1; b_if_addr = 32'h18;
    sample;
    chk("b_if_gnt", b_if_gnt, 1);
    next; b_if_req = 1'b0;
    sample;
    chk("b_lat_wait1", b_if_rvalid, 0);
    next;
    sample;
    chk("b_lat_wait2", b_if_rvalid, 0);
    next;
    sample;
    chk("b_lat_rvalid", b_if_rvalid, 1);
    chk("b_lat_rdata", b_if_rdata, 32'hC0DE0018);

    // Flush: IF 0x10, data 0x20, IF 0x14 with flush
    next; b_if_req = 1'b1; b_if_addr = 32'h10;
    sample;
    chk("fl_if_gnt0", b_if_gnt, 1);
    next; b_if_addr = 32'h14; b_d_req = 1'b1; b_d_addr = 32'h20;
    sample;
    chk("fl_d_gnt", b_d_gnt, 1);
    chk("fl_stall_if", b_stall_if, 1);
    next; b_d_req = 1'b0; b_flush = 1'b1;
    sample;
    chk("fl_if_gnt1", b_if_gnt, 1);
    next; b_if_req = 1'b0; b_flush = 1'b0;
    sample;
    chk("fl_kill_0x10", b_if_rvalid, 0);
    next;
    sample;
    chk("fl_d_rvalid", b_d_rvalid, 1);
    chk("fl_d_rdata", b_d_rdata, 32'hC0DE0020);
    chk("fl_if_rvalid_f4", b_if_rvalid, 0);
    next;
    sample;
    chk("fl_kill_0x14", b_if_rvalid, 0);
    chk("fl_if_rdata_hold", b_if_rdata, 32'hC0DE0018);
    next;
    sample;
    chk("fl_if_rvalid_f6", b_if_rvalid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-ported unified instruction/data memory between the pipeline's fetch port (IF) and its load/store port (MEM stage). One request is issued per cycle. Read data is returned to the requester after a fixed memory latency, and each port gets a stall signal. The block sits between the pipeline registers and the memory macro. It replaces the split instruction and data memories, and adds a flush input that drops in-flight fetch returns on a taken jump or branch.

## Interface
- ADDR_W, 32, address width (byte addresses, word aligned)
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from a granted read to valid `mem_rdata`; legal range 1..4
- STARVE_MAX, 4, consecutive denied IF cycles before IF is forced to win

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- if_req  in  1  fetch request; held with `if_addr` stable until granted
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_W  fetch data
- stall_if  out  1  `if_req & ~if_gnt`
- d_req  in  1  data request; held with `d_we`, `d_addr` and `d_wdata` stable until granted
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- stall_mem  out  1  `d_req & ~d_gnt`
- flush  in  1  squash all fetch reads in flight, including one granted this cycle
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the access

## Operation
- **Grant logic** is combinational from the request inputs and registered state. At most one of `if_gnt` / `d_gnt` is high per cycle.
- **Grant state machine** has three states, updated each cycle:
  - GS_NONE: no grant.
  - GS_DATA: data port won.
  - GS_INST: IF won.
- **Arbitration priority:** data wins over IF (it belongs to the older instruction), except when `starve_cnt == STARVE_MAX` and `if_req` is high; then IF wins that cycle.
- **Starve counter** `starve_cnt` (3 bits, saturating at STARVE_MAX):
  - increments when `if_req & ~if_gnt`;
  - clears when `if_gnt` or `~if_req`.
- **Memory outputs:** on a grant, `mem_en = 1` and `mem_addr`, `mem_we`, `mem_wdata` carry the winner's fields. IF requests always have `mem_we = 0`. With no grant, `mem_en = 0` and `mem_we = 0`.
- **Return tracking:** a tag pipe of MEM_LAT entries, each `{valid, src}` with `src` = 0 for IF and 1 for data.
  - A read grant pushes `{1, src}`.
  - A store or idle cycle pushes `{0, x}`.
  - The head entry routes `mem_rdata` to `if_rdata` or `d_rdata` and raises the matching rvalid.
  - The unselected rdata output holds its last value.
- **Flush:** `flush = 1` clears `valid` on every IF-tagged entry in the pipe and on the IF entry being pushed that cycle. Data-tagged entries are untouched. `flush` does not affect grants.
- **Boundary cases:**
  - Both ports requesting with the counter below STARVE_MAX: data wins.
  - Back-to-back grants return in issue order with no bubble.
  - Store followed by a load to the same address: the load returns the new value (the memory macro guarantees write-before-read).
- **Reset assertion**, even mid-access, has these effects:
  - Tag pipe cleared and pending returns dropped.
  - State machine to GS_NONE; `starve_cnt = 0`.
  - `if_rdata` and `d_rdata` cleared to 0.
  - All grant, rvalid and `mem_*` outputs forced to 0.

## Timing
- Grant and stall are same-cycle combinational with respect to the requests. A request granted in cycle N completes at the edge ending cycle N.
- A read granted in cycle N returns rvalid and rdata in cycle N+MEM_LAT. The rvalid pulse lasts one cycle.
- Stores produce no rvalid.
- Throughput is one access per cycle.
- Maximum IF wait under continuous data traffic is STARVE_MAX cycles; IF is granted in cycle STARVE_MAX+1.
- The first grant is possible in the first cycle after `reset` deasserts.

## Structure
- Shared package `mem_arb_pkg` holds:
  - state encodings GS_NONE = 2'd0, GS_DATA = 2'd1, GS_INST = 2'd2;
  - tag constants SRC_IF = 1'b0, SRC_D = 1'b1;
  - the tag entry type `{valid, src}`.
- One sub-module, `arb_tag_pipe`: the MEM_LAT-deep `{valid, src}` shift register with a per-entry flush clear.
- Grant, counter and output multiplexing live in the top level.

## Test plan
- **Reset:** hold `reset` = 0 with both requests high → all outputs 0. Release → IF alone at 0x100 is granted the same cycle, and with MEM_LAT = 1, `if_rvalid` rises the next cycle with the memory word.
- **Contention:** `if_req` and `d_req` (load 0x200) both high → `d_gnt = 1`, `stall_if = 1`, and `d_rvalid` returns the data at 0x200 MEM_LAT cycles later.
- **Starvation:** continuous loads with `if_req` held and STARVE_MAX = 4 → `d_gnt` for 4 cycles, `if_gnt` in cycle 5, `d_gnt` resumes in cycle 6, and `starve_cnt` returns to 0.
- **Store then load:** store 0xDEADBEEF to 0x40, then load 0x40 → no rvalid for the store, and `d_rdata = 0xDEADBEEF` on `d_rvalid`.
- **Flush:** with MEM_LAT = 3, grant IF at 0x10 and 0x14 with a data load in between, then assert `flush` → no `if_rvalid` for either fetch, and `d_rvalid` still appears on time.
- **Reset mid-access:** assert `reset` while a read is in flight → no rvalid after release, and the tag pipe is empty.
